// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ccff_ld_state_e;

  // Bits needed to hold any count in 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_rb_packer.sv
// Packs ccff_tail samples into readback words; the last chain bit flushes a partial word.
module ccff_rb_packer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              tail,
  input  logic              flush,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_nxt;

  always_comb begin
    acc_nxt      = acc;
    acc_nxt[idx] = tail;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      acc      <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (sample_en) begin
        // acc is cleared on every emit, so a flushed partial word is zero-padded
        if (flush || idx == IDX_W'(WORD_W - 1)) begin
          rb_data  <= acc_nxt;
          rb_valid <= 1'b1;
          acc      <= '0;
          idx      <= '0;
        end else begin
          acc <= acc_nxt;
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain initiator: serialises bitstream words onto ccff_head and
// returns the bits leaving the chain as readback words.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 9
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              io_isol_n
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);
  localparam int WL_W  = cnt_width(WORD_W);

  ccff_ld_state_e    state;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  bits_left;
  logic [WL_W-1:0]   word_left;
  logic [WL_W-1:0]   word_len;
  logic              last_bit;

  assign bs_ready = (state == ST_LOAD);
  assign last_bit = (state == ST_SHIFT) && (bits_left == CNT_W'(1));
  assign word_len = (int'(bits_left) >= WORD_W) ? WL_W'(WORD_W) : WL_W'(bits_left);

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bits_left   <= '0;
      word_left   <= '0;
      ccff_head   <= 1'b0;
      ccff_clk_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      io_isol_n   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_LOAD;
            io_isol_n <= 1'b0;
            busy      <= 1'b1;
            bits_left <= CNT_W'(CHAIN_LEN);
          end
        end
        ST_LOAD: begin
          if (bs_valid) begin
            shreg       <= bs_data;
            ccff_head   <= bs_data[0];
            ccff_clk_en <= 1'b1;
            word_left   <= word_len;
            state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // head/clk_en are registered one bit ahead so head holds its last value once shifting stops
          shreg     <= shreg >> 1;
          bits_left <= bits_left - CNT_W'(1);
          word_left <= word_left - WL_W'(1);
          if (bits_left == CNT_W'(1)) begin
            ccff_clk_en <= 1'b0;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else if (word_left == WL_W'(1)) begin
            ccff_clk_en <= 1'b0;
            state       <= ST_LOAD;
          end else begin
            ccff_head <= shreg[1];
          end
        end
        ST_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          io_isol_n <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ccff_rb_packer #(
    .WORD_W (WORD_W)
  ) u_rb_packer (
    .clk       (prog_clk),
    .rst_n     (prog_reset_n),
    .sample_en (ccff_clk_en),
    .tail      (ccff_tail),
    .flush     (last_bit),
    .rb_data   (rb_data),
    .rb_valid  (rb_valid)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: 9-flop reference chain, table of directed loads,
// plus start-while-busy and mid-load reset sequences.
module tb_ccff_chain_loader;

  logic       prog_clk = 1'b0;
  logic       prog_reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bs_data = '0;
  logic       bs_valid = 1'b0;
  logic       bs_ready;
  logic       ccff_head;
  logic       ccff_clk_en;
  logic       ccff_tail;
  logic [7:0] rb_data;
  logic       rb_valid;
  logic       busy;
  logic       done;
  logic       io_isol_n;

  // chain[i] ends up holding the i-th bit shifted in; chain[0] is the tail
  logic [8:0] chain = '0;
  logic [8:0] pre_val = '0;
  logic       pre_load = 1'b0;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         n_en, n_rb, n_done;
  logic [8:0] head_bits;
  logic [7:0] rb_w [0:3];

  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    int         stall;
    logic [8:0] pre;
    bit         mid_start;
    logic [8:0] exp_chain;
    logic [7:0] exp_rb0;
    logic [7:0] exp_rb1;
  } vec_t;

  vec_t vecs [0:4];

  always #5 prog_clk = ~prog_clk;

  assign ccff_tail = chain[0];

  always @(posedge prog_clk) begin
    if (pre_load)         chain <= pre_val;
    else if (ccff_clk_en) chain <= {ccff_head, chain[8:1]};
  end

  ccff_chain_loader #(
    .WORD_W    (8),
    .CHAIN_LEN (9)
  ) dut (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .start        (start),
    .bs_data      (bs_data),
    .bs_valid     (bs_valid),
    .bs_ready     (bs_ready),
    .ccff_head    (ccff_head),
    .ccff_clk_en  (ccff_clk_en),
    .ccff_tail    (ccff_tail),
    .rb_data      (rb_data),
    .rb_valid     (rb_valid),
    .busy         (busy),
    .done         (done),
    .io_isol_n    (io_isol_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sample at negedge, then advance to just after the next rising edge.
  task automatic step();
    @(negedge prog_clk);
    if (ccff_clk_en) begin
      if (n_en < 9) head_bits[n_en] = ccff_head;
      n_en++;
    end
    if (rb_valid) begin
      if (n_rb < 4) rb_w[n_rb] = rb_data;
      n_rb++;
    end
    if (done) n_done++;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic preload(input logic [8:0] v);
    pre_val  = v;
    pre_load = 1'b1;
    @(posedge prog_clk);
    #1;
    pre_load = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                          input int stall, input logic [8:0] pre, input bit mid_start);
    int idx, stall_left, cyc;
    preload(pre);
    n_en = 0; n_rb = 0; n_done = 0; head_bits = '0;
    for (int i = 0; i < 4; i++) rb_w[i] = '0;
    idx = 0; stall_left = stall; cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (n_done == 0 && cyc < 200) begin
      bs_valid = 1'b0;
      start    = mid_start && (n_en == 3);
      if (bs_ready && idx < 2) begin
        if (idx == 1 && stall_left > 0) begin
          stall_left--;
          check({tag, "_stall_clk_en"}, 32'(ccff_clk_en), 32'd0);
        end else begin
          bs_valid = 1'b1;
          bs_data  = (idx == 0) ? w0 : w1;
          idx++;
        end
      end
      step();
      cyc++;
    end
    bs_valid = 1'b0;
    start    = 1'b0;
    if (n_done == 0) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    if (stall > 0) check({tag, "_stall_cycles"}, 32'(stall - stall_left), 32'(stall));
  endtask

  task automatic verify(input string tag, input logic [8:0] exp_chain,
                        input logic [7:0] exp_rb0, input logic [7:0] exp_rb1);
    check({tag, "_busy_after"},  32'(busy),      32'd0);
    check({tag, "_isol_after"},  32'(io_isol_n), 32'd1);
    check({tag, "_done_after"},  32'(done),      32'd0);
    step();
    step();
    check({tag, "_enables"},  32'(n_en),      32'd9);
    check({tag, "_dones"},    32'(n_done),    32'd1);
    check({tag, "_rb_count"}, 32'(n_rb),      32'd2);
    check({tag, "_heads"},    32'(head_bits), 32'(exp_chain));
    check({tag, "_chain"},    32'(chain),     32'(exp_chain));
    check({tag, "_rb0"},      32'(rb_w[0]),   32'(exp_rb0));
    check({tag, "_rb1"},      32'(rb_w[1]),   32'(exp_rb1));
  endtask

  initial begin
    int  cyc;
    bit  fed;

    vecs[0] = '{8'hA5, 8'h01, 0, 9'h000, 1'b0, 9'h1A5, 8'h00, 8'h00};
    vecs[1] = '{8'h00, 8'h00, 0, 9'h1FF, 1'b0, 9'h000, 8'hFF, 8'h01};
    vecs[2] = '{8'hA5, 8'h01, 5, 9'h1A5, 1'b0, 9'h1A5, 8'hA5, 8'h01};
    vecs[3] = '{8'hA5, 8'hFE, 0, 9'h0F0, 1'b0, 9'h0A5, 8'hF0, 8'h00};
    vecs[4] = '{8'h3C, 8'h01, 0, 9'h100, 1'b1, 9'h13C, 8'h00, 8'h01};

    repeat (2) @(posedge prog_clk);
    #1;
    check("reset_outputs",
          32'({bs_ready, ccff_head, ccff_clk_en, rb_valid, busy, done, io_isol_n, rb_data}), 32'd0);
    prog_reset_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      run_load(tag, vecs[i].w0, vecs[i].w1, vecs[i].stall, vecs[i].pre, vecs[i].mid_start);
      verify(tag, vecs[i].exp_chain, vecs[i].exp_rb0, vecs[i].exp_rb1);
    end

    // Reset after four shift edges of 0xA5: chain must freeze with bits 1,0,1,0 at the top.
    preload(9'h000);
    n_en = 0; n_rb = 0; n_done = 0; head_bits = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0; fed = 1'b0;
    while (n_en < 4 && cyc < 50) begin
      bs_valid = 1'b0;
      if (bs_ready && !fed) begin
        bs_valid = 1'b1;
        bs_data  = 8'hA5;
        fed      = 1'b1;
      end
      step();
      cyc++;
    end
    bs_valid = 1'b0;
    check("rst_reach_4_shifts", 32'(n_en), 32'd4);
    prog_reset_n = 1'b0;
    #1;
    check("rst_async_outputs",
          32'({bs_ready, ccff_head, ccff_clk_en, rb_valid, busy, done, io_isol_n, rb_data}), 32'd0);
    repeat (3) @(posedge prog_clk);
    #1;
    check("rst_frozen_chain", 32'(chain), 32'h0A0);
    check("rst_held_clk_en", 32'(ccff_clk_en), 32'd0);
    prog_reset_n = 1'b1;
    step();

    run_load("post_rst", 8'hA5, 8'h01, 0, 9'h000, 1'b0);
    verify("post_rst", 9'h1A5, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Initiator for the configuration-chain protocol: serialises a word-wide bitstream onto `ccff_head`, one bit per shift cycle, for a chain of `CHAIN_LEN` configuration flops.
- Captures the bits leaving the chain on `ccff_tail` and returns them as readback words.
- Drives `ccff_clk_en`, which gates `prog_clk` to the fabric chain, and the active-low IO isolation used by the IO grid tiles.
- Sits between the bitstream source (SoC or test port) and the fabric's top-level `ccff_head`/`ccff_tail`.

Parameters:
- `WORD_W`, 8, bitstream and readback word width.
- `CHAIN_LEN`, 9, total configuration flops in the chain (≥1).
- `CNT_W`, `$clog2(CHAIN_LEN+1)`, width of the bit counter (derived, not overridden).

Ports:
- `prog_clk`  in  1  programming clock; all state on rising edge.
- `prog_reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; ignored unless IDLE.
- `bs_data`  in  `WORD_W`  bitstream word; bit 0 is shifted first.
- `bs_valid`  in  1  `bs_data` valid.
- `bs_ready`  out  1  loader accepts a word this cycle.
- `ccff_head`  out  1  serial data into the chain.
- `ccff_clk_en`  out  1  fabric chain captures at the end of this cycle.
- `ccff_tail`  in  1  serial data out of the chain.
- `rb_data`  out  `WORD_W`  readback word; first-captured bit in bit 0, unused upper bits 0.
- `rb_valid`  out  1  one-cycle strobe, no backpressure.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse when the last bit has been shifted.
- `io_isol_n`  out  1  0 = IO isolated.

Behaviour:
- Reset values: `bs_ready`=0, `ccff_head`=0, `ccff_clk_en`=0, `rb_data`=0, `rb_valid`=0, `busy`=0, `done`=0, `io_isol_n`=0. State = IDLE, counters = 0.
- FSM states are IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - `start`=1 → LOAD.
  - At the same edge: `io_isol_n`←0, `busy`←1, `bits_left`←`CHAIN_LEN`.
- LOAD:
  - `bs_ready`=1 (combinational from state).
  - On `bs_valid`&&`bs_ready`: latch the word into the shift register, set `word_left`←min(`WORD_W`, `bits_left`), go to SHIFT.
  - No accept → hold; `ccff_clk_en` stays 0 and no fabric shift occurs.
- SHIFT:
  - Each cycle: `ccff_head` = shreg[0] and `ccff_clk_en`=1.
  - At the edge: sample `ccff_tail` into the readback packer, shift shreg right, decrement `word_left` and `bits_left`.
  - `word_left` reaching 0 with `bits_left`>0 → LOAD.
  - `bits_left` reaching 0 → DONE.
  - One bubble cycle (LOAD) per word, minimum.
- Partial last word: only the low (`CHAIN_LEN` mod `WORD_W`) bits are shifted; the upper bits of that word are discarded.
- DONE (one cycle): `done`=1, `busy`←0, `io_isol_n`←1, → IDLE. `io_isol_n` stays 1 until the next `start`.
- Readback packer:
  - Bit k of each word = k-th `ccff_tail` sample within that word period.
  - `rb_valid` pulses for one cycle on the cycle after the word's final shift edge (a full word, or the final partial word zero-padded).
  - Exactly ceil(`CHAIN_LEN`/`WORD_W`) strobes per load.
- `ccff_head` holds its last value outside SHIFT; only `ccff_clk_en` qualifies it.
- `start` while busy: ignored, no side effects.
- Reset mid-load: everything returns to reset values immediately (async). `ccff_clk_en` drops at once, so the chain stays frozen with partial contents. `io_isol_n`=0.
- `CHAIN_LEN` < `WORD_W`: a single word is consumed, then straight to DONE.

Decomposition:
- Package `ccff_loader_pkg`:
  - FSM state enum `ccff_ld_state_e` (IDLE/LOAD/SHIFT/DONE).
  - Counter-width function used by `CNT_W`.
- Sub-module `ccff_rb_packer`:
  - Serial-to-word shift register with bit counter.
  - `rb_valid` generation.
  - Flush on last bit.

Test Plan:
- Reference chain model: 9 flops clocked when `ccff_clk_en`, with `WORD_W`=8 and `CHAIN_LEN`=9 unless noted.
- Nominal load: words 0xA5 then 0x01.
  - `ccff_head` sequence on `ccff_clk_en` cycles = 1,0,1,0,0,1,0,1,1.
  - Exactly 9 enable cycles, then `done` pulse.
  - `io_isol_n` 0→1 at DONE; model chain reads 9'h1A5.
- Readback: model preloaded with 9'h1FF, load 0x00,0x00.
  - `rb_data` 0xFF then 0x01, two `rb_valid` strobes.
  - Chain afterwards all 0.
- Backpressure: withhold `bs_valid` for 5 cycles before the second word.
  - `ccff_clk_en`=0 and `bs_ready`=1 throughout the stall.
  - Final chain contents unchanged vs nominal.
- Partial word: second word 0xFE.
  - Only bit0 (0) shifted; 9th head bit = 0.
  - Exactly 9 enables.
- `start` asserted in SHIFT: no restart, `bits_left` unaffected, single `done`.
- `prog_reset_n` pulsed low after 4 shift cycles: all outputs return to reset values asynchronously.
  - Model chain frozen holding 4 new bits.
  - A subsequent `start` performs a full 9-bit load correctly.
